// File: rtl/sharp_pkg.sv
// Shared definitions for the sharpened-pixel write-back path:
// FSM states, lane count, full-word mask and per-lane mask lookups.
package sharp_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PACK  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam int LANES = 4;

   localparam logic [31:0] FULL_MASK = 32'hFFFF_FFFF;

   // lane k occupies byte k counted from the LSB
   localparam logic [31:0] LANE_MASK_LE [LANES] = '{
      32'h0000_00FF,
      32'h0000_FF00,
      32'h00FF_0000,
      32'hFF00_0000
   };

   // lane k occupies byte k counted from the MSB
   localparam logic [31:0] LANE_MASK_BE [LANES] = '{
      32'hFF00_0000,
      32'h00FF_0000,
      32'h0000_FF00,
      32'h0000_00FF
   };

endpackage

// File: rtl/sharp_lane_mask.sv
// Lane index to byte-lane mask and bit shift within the 32-bit word.
// Ports: lane (in, 2), mask (out, 32), shift (out, 5).
// Endianness: BIG_ENDIAN_PACK_EN selects MSB-first lane order.
module sharp_lane_mask
   import sharp_pkg::*;
(
   input  logic [1:0]  lane,
   output logic [31:0] mask,
   output logic [4:0]  shift
);

`ifdef BIG_ENDIAN_PACK_EN
   // 24 - 8k == 8 * (3 - k) == 8 * ~k for a 2-bit k
   assign mask  = LANE_MASK_BE[lane];
   assign shift = {~lane, 3'b000};
`else
   assign mask  = LANE_MASK_LE[lane];
   assign shift = {lane, 3'b000};
`endif

endmodule

// File: rtl/sharp_pixel_writer.sv
// Packs 8-bit sharpened pixels four per word and writes them to data memory.
// Ports: clk, reset (async high), start, base_addr, pix_valid/data/last,
// pix_ready, mem_req/addr/wdata/mask, mem_ack, busy, done.
// Build option: BIG_ENDIAN_PACK_EN packs lane 0 into the MSB byte.
module sharp_pixel_writer
   import sharp_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int PIX_W  = 8
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              pix_valid,
   input  logic [PIX_W-1:0]  pix_data,
   input  logic              pix_last,
   output logic              pix_ready,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [31:0]       mem_mask,
   input  logic              mem_ack,
   output logic              busy,
   output logic              done
);

   localparam int WORD_W = LANES * PIX_W;

   state_t            state;
   state_t            state_nxt;
   logic [1:0]        lane;
   logic              last_seen;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       word;
   logic [31:0]       mask;
   logic [31:0]       lane_mask;
   logic [4:0]        lane_shift;
   logic [31:0]       pix_ext;
   logic              take;

   sharp_lane_mask u_lane_mask (
      .lane  (lane),
      .mask  (lane_mask),
      .shift (lane_shift)
   );

   assign pix_ext = {{(WORD_W-PIX_W){1'b0}}, pix_data};
   assign take    = pix_valid && (state == S_PACK);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // handshake outputs decode straight from the state register so that
   // reset clears them without waiting for a clock edge
   always_comb begin
      state_nxt = state;
      pix_ready = 1'b0;
      mem_req   = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start) state_nxt = S_PACK;
         end
         S_PACK: begin
            pix_ready = 1'b1;
            busy      = 1'b1;
            if (take && (lane == 2'd3 || pix_last))
               state_nxt = S_WRITE;
         end
         S_WRITE: begin
            mem_req = 1'b1;
            busy    = 1'b1;
            if (mem_ack)
               state_nxt = last_seen ? S_DONE : S_PACK;
         end
         S_DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lane      <= 2'd0;
         last_seen <= 1'b0;
         addr      <= '0;
         word      <= '0;
         mask      <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  addr      <= base_addr & ~ADDR_W'(3);
                  lane      <= 2'd0;
                  last_seen <= 1'b0;
                  word      <= '0;
                  mask      <= '0;
               end
            end
            S_PACK: begin
               if (take) begin
                  word <= word | (pix_ext << lane_shift);
                  mask <= mask | lane_mask;
                  lane <= lane + 2'd1;
                  if (pix_last) last_seen <= 1'b1;
               end
            end
            S_WRITE: begin
               // word/mask/addr frozen until the ack so the
               // request stays stable for the whole WRITE
               if (mem_ack && !last_seen) begin
                  addr <= addr + ADDR_W'(4);
                  lane <= 2'd0;
                  word <= '0;
                  mask <= '0;
               end
            end
            S_DONE: begin
            end
            default: begin
            end
         endcase
      end
   end

   assign mem_addr  = addr;
   assign mem_wdata = word;
   assign mem_mask  = mask;

endmodule

// File: tb/tb_sharp_pixel_writer.sv
// Directed self-checking bench for sharp_pixel_writer.
// Memory responder acks after a programmable delay and logs each write.
module tb_sharp_pixel_writer;

`ifdef BIG_ENDIAN_PACK_EN
   localparam logic [31:0] W1A = 32'h0102_0304;
   localparam logic [31:0] W1B = 32'h0506_0708;
   localparam logic [31:0] W2A = 32'hAAAB_ACAD;
   localparam logic [31:0] W2B = 32'hAEAF_0000;
   localparam logic [31:0] M2B = 32'hFFFF_0000;
   localparam logic [31:0] W3A = 32'h3132_3334;
   localparam logic [31:0] W3B = 32'h3536_3738;
   localparam logic [31:0] W4  = 32'h0506_0708;
   localparam logic [31:0] W5A = 32'h5152_5354;
   localparam logic [31:0] W5B = 32'h5556_0000;
   localparam logic [31:0] M5B = 32'hFFFF_0000;
   localparam logic [31:0] W6  = 32'h1122_3300;
   localparam logic [31:0] M6  = 32'hFFFF_FF00;
   localparam logic [31:0] W7A = 32'h6162_6364;
   localparam logic [31:0] W7B = 32'h6566_6768;
`else
   localparam logic [31:0] W1A = 32'h0403_0201;
   localparam logic [31:0] W1B = 32'h0807_0605;
   localparam logic [31:0] W2A = 32'hADAC_ABAA;
   localparam logic [31:0] W2B = 32'h0000_AFAE;
   localparam logic [31:0] M2B = 32'h0000_FFFF;
   localparam logic [31:0] W3A = 32'h3433_3231;
   localparam logic [31:0] W3B = 32'h3837_3635;
   localparam logic [31:0] W4  = 32'h0807_0605;
   localparam logic [31:0] W5A = 32'h5453_5251;
   localparam logic [31:0] W5B = 32'h0000_5655;
   localparam logic [31:0] M5B = 32'h0000_FFFF;
   localparam logic [31:0] W6  = 32'h0033_2211;
   localparam logic [31:0] M6  = 32'h00FF_FFFF;
   localparam logic [31:0] W7A = 32'h6463_6261;
   localparam logic [31:0] W7B = 32'h6867_6665;
`endif
   localparam logic [31:0] FULL = 32'hFFFF_FFFF;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] base_addr;
   logic        pix_valid;
   logic [7:0]  pix_data;
   logic        pix_last;
   logic        pix_ready;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_mask;
   logic        mem_ack;
   logic        busy;
   logic        done;

   int n_checks = 0;
   int n_fail   = 0;
   int ack_dly  = 0;
   int wcnt     = 0;
   int done_cnt = 0;

   logic [31:0] cap_a, cap_d, cap_m;
   logic [31:0] wq_a[$], wq_d[$], wq_m[$];
   logic [31:0] ex_a[$], ex_d[$], ex_m[$];

   sharp_pixel_writer dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .base_addr (base_addr),
      .pix_valid (pix_valid),
      .pix_data  (pix_data),
      .pix_last  (pix_last),
      .pix_ready (pix_ready),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_mask  (mem_mask),
      .mem_ack   (mem_ack),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // memory side: capture, hold-stability, ack after ack_dly cycles
   initial begin
      mem_ack = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         mem_ack = 1'b0;
         if (done) done_cnt++;
         if (mem_req) begin
            check("ready_in_write", {31'b0, pix_ready}, 32'd0);
            if (wcnt == 0) begin
               cap_a = mem_addr;
               cap_d = mem_wdata;
               cap_m = mem_mask;
            end else begin
               check("hold_addr", mem_addr, cap_a);
               check("hold_data", mem_wdata, cap_d);
               check("hold_mask", mem_mask, cap_m);
            end
            if (wcnt >= ack_dly) begin
               mem_ack = 1'b1;
               wq_a.push_back(cap_a);
               wq_d.push_back(cap_d);
               wq_m.push_back(cap_m);
               wcnt = 0;
            end else begin
               wcnt++;
            end
         end else begin
            wcnt = 0;
         end
      end
   end

   task automatic do_start(input logic [31:0] b);
      start     = 1'b1;
      base_addr = b;
      tick();
      start     = 1'b0;
   endtask

   task automatic send(input logic [7:0] d, input logic l);
      int g;
      g = 0;
      pix_valid = 1'b1;
      pix_data  = d;
      pix_last  = l;
      while (!pix_ready && g < 200) begin
         tick();
         g++;
      end
      if (!pix_ready)
         check("send_timeout", {31'b0, pix_ready}, 32'd1);
      tick();
   endtask

   task automatic wait_idle(input string tag);
      int g;
      g = 0;
      pix_valid = 1'b0;
      pix_last  = 1'b0;
      while (busy && g < 300) begin
         tick();
         g++;
      end
      check({tag, "_idle"}, {31'b0, busy}, 32'd0);
   endtask

   task automatic expect_w(input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] m);
      ex_a.push_back(a);
      ex_d.push_back(d);
      ex_m.push_back(m);
   endtask

   task automatic cmp_frame(input string tag, input int d0, input int nd);
      check({tag, "_nwr"}, 32'(wq_a.size()), 32'(ex_a.size()));
      check({tag, "_done"}, 32'(done_cnt - d0), 32'(nd));
      for (int i = 0; i < ex_a.size() && i < wq_a.size(); i++) begin
         check($sformatf("%s_addr%0d", tag, i), wq_a[i], ex_a[i]);
         check($sformatf("%s_data%0d", tag, i), wq_d[i], ex_d[i]);
         check($sformatf("%s_mask%0d", tag, i), wq_m[i], ex_m[i]);
      end
      wq_a.delete(); wq_d.delete(); wq_m.delete();
      ex_a.delete(); ex_d.delete(); ex_m.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      reset     = 1'b1;
      start     = 1'b0;
      base_addr = '0;
      pix_valid = 1'b0;
      pix_data  = '0;
      pix_last  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", {31'b0, pix_ready}, 32'd0);
      check("rst_req",   {31'b0, mem_req},   32'd0);
      check("rst_busy",  {31'b0, busy},      32'd0);
      check("rst_done",  {31'b0, done},      32'd0);
      check("rst_addr",  mem_addr,  32'd0);
      check("rst_data",  mem_wdata, 32'd0);
      check("rst_mask",  mem_mask,  32'd0);
      reset = 1'b0;
      tick();

      // two full words, ack one cycle after req
      ack_dly = 0;
      d0 = done_cnt;
      do_start(32'h100);
      for (int i = 1; i <= 8; i++) send(8'(i), i == 8);
      wait_idle("t1");
      expect_w(32'h100, W1A, FULL);
      expect_w(32'h104, W1B, FULL);
      cmp_frame("t1", d0, 1);

      // six pixels, partial second word
      d0 = done_cnt;
      do_start(32'h180);
      for (int i = 0; i < 6; i++) send(8'hAA + 8'(i), i == 5);
      wait_idle("t2");
      expect_w(32'h180, W2A, FULL);
      expect_w(32'h184, W2B, M2B);
      cmp_frame("t2", d0, 1);

      // slow ack with valid held throughout
      ack_dly = 5;
      d0 = done_cnt;
      do_start(32'h1C0);
      for (int i = 0; i < 8; i++) send(8'h31 + 8'(i), i == 7);
      wait_idle("t3");
      expect_w(32'h1C0, W3A, FULL);
      expect_w(32'h1C4, W3B, FULL);
      cmp_frame("t3", d0, 1);

      // reset while a request is outstanding
      ack_dly = 40;
      d0 = done_cnt;
      do_start(32'h1E0);
      for (int i = 0; i < 4; i++) send(8'h41 + 8'(i), 1'b0);
      begin
         int g;
         g = 0;
         while (!mem_req && g < 20) begin
            tick();
            g++;
         end
      end
      check("t4_req_up", {31'b0, mem_req}, 32'd1);
      tick();
      #2;
      reset = 1'b1;
      #1;
      check("t4_req_rst",   {31'b0, mem_req},   32'd0);
      check("t4_busy_rst",  {31'b0, busy},      32'd0);
      check("t4_ready_rst", {31'b0, pix_ready}, 32'd0);
      check("t4_data_rst",  mem_wdata, 32'd0);
      @(posedge clk);
      #1;
      reset     = 1'b0;
      pix_valid = 1'b0;
      ack_dly   = 0;
      tick();
      tick();
      cmp_frame("t4a", d0, 0);
      d0 = done_cnt;
      do_start(32'h200);
      for (int i = 0; i < 4; i++) send(8'h05 + 8'(i), i == 3);
      wait_idle("t4b");
      expect_w(32'h200, W4, FULL);
      cmp_frame("t4b", d0, 1);

      // start while busy is ignored
      d0 = done_cnt;
      do_start(32'h400);
      send(8'h51, 1'b0);
      send(8'h52, 1'b0);
      pix_valid = 1'b0;
      do_start(32'h300);
      for (int i = 0; i < 4; i++) send(8'h53 + 8'(i), i == 3);
      wait_idle("t5");
      expect_w(32'h400, W5A, FULL);
      expect_w(32'h404, W5B, M5B);
      cmp_frame("t5", d0, 1);

      // three-pixel frame, unaligned base low bits dropped
      d0 = done_cnt;
      do_start(32'h503);
      send(8'h11, 1'b0);
      send(8'h22, 1'b0);
      send(8'h33, 1'b1);
      wait_idle("t6");
      expect_w(32'h500, W6, M6);
      cmp_frame("t6", d0, 1);

      // address wrap past 2^32
      d0 = done_cnt;
      do_start(32'hFFFF_FFFC);
      for (int i = 0; i < 8; i++) send(8'h61 + 8'(i), i == 7);
      wait_idle("t7");
      expect_w(32'hFFFF_FFFC, W7A, FULL);
      expect_w(32'h0000_0000, W7B, FULL);
      cmp_frame("t7", d0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
